// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding,
// SRAM bus widths and default address map / timing.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned SRAM_ADDR_W         = 18;
    localparam int unsigned SRAM_DATA_W         = 16;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 3;
    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase hold counter: flags the last cycle of a phase and the cycle
// before it (used to release write-enable one cycle early).
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last,
    output logic o_pre_last
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_V  = CNT_W'((WAIT_CYCLES > 1) ? (WAIT_CYCLES - 2) : 0);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_last     = (r_count == LAST_V);
    assign o_pre_last = (WAIT_CYCLES > 1) && (r_count == PRE_V);

endmodule

// File: rtl/sram_ctrl.sv
// Splits one 32-bit MEM-stage load/store into two 16-bit async SRAM accesses.
// Optional access statistics enabled by defining SRAM_CTRL_STATS_EN.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
);

    localparam logic WE_LOW_ON_ENTRY = (WAIT_CYCLES > 1);

    state_t      r_state;
    logic        r_op_wr;
    logic [16:0] r_word;
    logic [15:0] r_data_hi;
    logic [31:0] r_read_data;
    logic [17:0] r_sram_addr;
    logic [15:0] r_dq_out;
    logic        r_dq_oe;
    logic        r_we_n;

    logic        w_req;
    logic [16:0] w_word;
    logic        w_last;
    logic        w_pre_last;
    logic        w_cnt_clr;
    logic        w_cnt_en;

    assign w_req  = wr_en | rd_en;
    assign w_word = 17'((address - BASE_ADDR) >> 2);

    assign w_cnt_clr = (r_state == ST_IDLE) || (r_state == ST_DONE) || w_last;
    assign w_cnt_en  = (r_state == ST_LO) || (r_state == ST_HI);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (w_cnt_clr),
        .i_en       (w_cnt_en),
        .o_last     (w_last),
        .o_pre_last (w_pre_last)
    );

    // SRAM pins are registered one edge ahead so they change only on phase
    // boundaries; WE rises one cycle before the address moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op_wr     <= 1'b0;
            r_word      <= '0;
            r_data_hi   <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_op_wr     <= wr_en;
                        r_word      <= w_word;
                        r_data_hi   <= write_data[31:16];
                        r_sram_addr <= {w_word, 1'b0};
                        if (wr_en) begin
                            r_dq_out <= write_data[15:0];
                        end
                        r_dq_oe <= wr_en;
                        r_we_n  <= !(wr_en && WE_LOW_ON_ENTRY);
                        r_state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (w_last) begin
                        if (!r_op_wr) begin
                            r_read_data[15:0] <= sram_dq_in;
                        end
                        r_sram_addr <= {r_word, 1'b1};
                        if (r_op_wr) begin
                            r_dq_out <= r_data_hi;
                        end
                        r_dq_oe <= r_op_wr;
                        r_we_n  <= !(r_op_wr && WE_LOW_ON_ENTRY);
                        r_state <= ST_HI;
                    end else if (w_pre_last) begin
                        r_we_n <= 1'b1;
                    end
                end
                ST_HI: begin
                    if (w_last) begin
                        if (!r_op_wr) begin
                            r_read_data[31:16] <= sram_dq_in;
                        end
                        r_dq_oe <= 1'b0;
                        r_we_n  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_pre_last) begin
                        r_we_n <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ready = 1'b0;
        case (r_state)
            ST_IDLE: ready = !w_req;
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (r_state == ST_DONE) begin
            if (r_op_wr) begin
                r_wr_count <= r_wr_count + 16'd1;
            end else begin
                r_rd_count <= r_rd_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default-timing instance against a small SRAM
// model plus a WAIT_CYCLES=1 instance for minimum latency.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    logic        f_rd_en;
    logic        f_wr_en;
    logic [31:0] f_address;
    logic [31:0] f_write_data;
    logic [31:0] f_read_data;
    logic        f_ready;
    logic [17:0] f_sram_addr;
    logic [15:0] f_dq_out;
    logic [15:0] f_dq_in;
    logic        f_dq_oe;
    logic        f_we_n;
    logic [15:0] f_rd_count;
    logic [15:0] f_wr_count;

    logic [15:0] mem [0:255];

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    sram_ctrl #(
        .WAIT_CYCLES(3),
        .BASE_ADDR  (32'd1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    sram_ctrl #(
        .WAIT_CYCLES(1),
        .BASE_ADDR  (32'd1024)
    ) dut_fast (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (f_wr_en),
        .rd_en      (f_rd_en),
        .address    (f_address),
        .write_data (f_write_data),
        .read_data  (f_read_data),
        .ready      (f_ready),
        .sram_addr  (f_sram_addr),
        .sram_dq_out(f_dq_out),
        .sram_dq_in (f_dq_in),
        .sram_dq_oe (f_dq_oe),
        .sram_we_n  (f_we_n),
        .rd_count   (f_rd_count),
        .wr_count   (f_wr_count)
    );

    // Simple synchronous stand-in for the async SRAM.
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in = mem[sram_addr[7:0]];
    assign f_dq_in    = 16'h1234;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Runs one access from cycle 0 (request seen in IDLE) through DONE and one idle cycle.
    task automatic run_access(input string tag, input logic wr, input logic rd,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [17:0] lo_addr, input logic [31:0] exp_rd);
        logic is_store;
        logic [17:0] exp_a;
        logic [15:0] exp_dq;
        is_store   = wr;
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = wdata;
        #1;
        check_eq($sformatf("%s_c0_ready", tag), ready, 0);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            check_eq($sformatf("%s_c%0d_ready", tag, c), ready, (c == 7) ? 1 : 0);
            if (c <= 6) begin
                exp_a  = (c <= 3) ? lo_addr : lo_addr + 18'd1;
                exp_dq = (c <= 3) ? wdata[15:0] : wdata[31:16];
                check_eq($sformatf("%s_c%0d_addr", tag, c), sram_addr, exp_a);
                if (is_store) begin
                    check_eq($sformatf("%s_c%0d_dq", tag, c), sram_dq_out, exp_dq);
                    check_eq($sformatf("%s_c%0d_oe", tag, c), sram_dq_oe, 1);
                    check_eq($sformatf("%s_c%0d_we_n", tag, c), sram_we_n, (c == 3 || c == 6) ? 1 : 0);
                end else begin
                    check_eq($sformatf("%s_c%0d_oe", tag, c), sram_dq_oe, 0);
                    check_eq($sformatf("%s_c%0d_we_n", tag, c), sram_we_n, 1);
                end
                if (!is_store && c == 4) begin
                    check_eq($sformatf("%s_c4_rd_lo", tag), read_data[15:0], exp_rd[15:0]);
                end
            end else begin
                check_eq($sformatf("%s_c7_oe", tag), sram_dq_oe, 0);
                check_eq($sformatf("%s_c7_we_n", tag), sram_we_n, 1);
                check_eq($sformatf("%s_c7_rdata", tag), read_data, exp_rd);
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk); #1;
        check_eq($sformatf("%s_idle_ready", tag), ready, 1);
    endtask

    initial begin
        logic [15:0] exp_wr_cnt;
        logic [15:0] exp_rd_cnt;
`ifdef SRAM_CTRL_STATS_EN
        exp_wr_cnt = 16'd3;
        exp_rd_cnt = 16'd2;
`else
        exp_wr_cnt = 16'd0;
        exp_rd_cnt = 16'd0;
`endif
        rst          = 1'b1;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        address      = '0;
        write_data   = '0;
        f_wr_en      = 1'b0;
        f_rd_en      = 1'b0;
        f_address    = '0;
        f_write_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        check_eq("rst_ready", ready, 1);
        check_eq("rst_we_n", sram_we_n, 1);
        check_eq("rst_oe", sram_dq_oe, 0);
        check_eq("rst_rdata", read_data, 0);
        check_eq("rst_addr", sram_addr, 0);
        check_eq("rst_dq", sram_dq_out, 0);
        check_eq("rst_wr_cnt", wr_count, 0);
        check_eq("rst_rd_cnt", rd_count, 0);

        // Store aborted by reset during its last LO cycle.
        wr_en      = 1'b1;
        address    = 32'd1028;
        write_data = 32'hAAAA5555;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("abort_c3_addr", sram_addr, 18'd2);
        check_eq("abort_c3_ready", ready, 0);
        rst   = 1'b1;
        wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_we_n", sram_we_n, 1);
        check_eq("abort_oe", sram_dq_oe, 0);
        check_eq("abort_ready", ready, 1);
        check_eq("abort_addr", sram_addr, 0);
        check_eq("abort_wr_cnt", wr_count, 0);
        @(posedge clk); #1;
        check_eq("abort_idle_addr", sram_addr, 0);

        run_access("st1",  1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h00000000);
        check_eq("mem0", mem[0], 16'hBEEF);
        check_eq("mem1", mem[1], 16'hDEAD);
        run_access("ld1",  1'b0, 1'b1, 32'd1024, 32'h00000000, 18'd0, 32'hDEADBEEF);
        run_access("both", 1'b1, 1'b1, 32'd1032, 32'h12345678, 18'd4, 32'hDEADBEEF);
        run_access("ld2",  1'b0, 1'b1, 32'd1035, 32'h00000000, 18'd4, 32'h12345678);
        run_access("st3",  1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 18'd6, 32'h12345678);
        check_eq("wr_count", wr_count, exp_wr_cnt);
        check_eq("rd_count", rd_count, exp_rd_cnt);

        // Minimum-latency instance: load with ready expected at cycle 3.
        f_rd_en   = 1'b1;
        f_address = 32'd2048;
        #1;
        check_eq("fast_c0_ready", f_ready, 0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            check_eq($sformatf("fast_c%0d_ready", c), f_ready, (c == 3) ? 1 : 0);
            if (c == 1) check_eq("fast_c1_addr", f_sram_addr, 18'd512);
            if (c == 2) check_eq("fast_c2_addr", f_sram_addr, 18'd513);
            check_eq($sformatf("fast_c%0d_we_n", c), f_we_n, 1);
        end
        check_eq("fast_rdata", f_read_data, 32'h12341234);
        f_rd_en = 1'b0;
        @(posedge clk); #1;
        check_eq("fast_idle_ready", f_ready, 1);
        check_eq("fast_rd_count", f_rd_count, exp_rd_cnt == 16'd0 ? 16'd0 : 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
